// File: rtl/pipe_stage_chain_pkg.sv
// Shared helpers for pipe_stage_chain: occupancy counter width and skid depth.
package pipe_stage_chain_pkg;

    localparam int SKID_ENTRIES = 2;

    // Enough bits to count DEPTH stages plus the optional skid entries.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One pipeline stage: valid/data registers, ready generation and synchronous flush.
module pipe_slice #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] DATA_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH:0]   up_state,
    input  logic             down_ready,
    output logic             ready,
    output logic [WIDTH:0]   state
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    assign up_valid = up_state[WIDTH];
    assign up_data  = up_state[WIDTH-1:0];

    // An empty stage always accepts, which collapses bubbles under back-pressure.
    assign ready = ~valid_q | down_ready;
    assign state = {valid_q, data_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= DATA_RST;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Back-pressurable DEPTH-stage register pipeline with flush and occupancy count.
// Define PIPE_STAGE_CHAIN_SKID_EN to add a 2-entry skid buffer that registers in_ready.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 3,
    parameter logic [WIDTH-1:0] DATA_RST = '0,
    localparam int              OCC_W    = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    // stage[0] feeds the first slice; stage[i+1] is the state held by slice i.
    stage_t [DEPTH:0] stage;
    logic   [DEPTH:0] ready;
    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_q;

    assign ready[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        pipe_slice #(
            .WIDTH    (WIDTH),
            .DATA_RST (DATA_RST)
        ) u_slice (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .up_state   (stage[i]),
            .down_ready (ready[i+1]),
            .ready      (ready[i]),
            .state      (stage[i+1])
        );
    end

`ifdef PIPE_STAGE_CHAIN_SKID_EN
    logic [1:0][WIDTH-1:0] skid_data;
    logic [1:0]            skid_count;
    logic                  skid_push;
    logic                  skid_pop;

    // in_ready decodes only registered skid state, so out_ready never reaches it.
    assign in_ready  = (skid_count != 2'(SKID_ENTRIES)) & ~flush;
    assign skid_push = in_valid & in_ready;
    assign skid_pop  = (skid_count != 2'd0) & ready[0];
    assign stage[0]  = {skid_count != 2'd0, skid_data[0]};
    assign in_xfer   = skid_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_count   <= 2'd0;
            skid_data[0] <= DATA_RST;
            skid_data[1] <= DATA_RST;
        end else if (flush) begin
            skid_count <= 2'd0;
        end else begin
            if (skid_pop) begin
                skid_data[0] <= skid_data[1];
            end
            if (skid_push) begin
                skid_data[skid_count[0] & ~skid_pop] <= in_data;
            end
            skid_count <= skid_count + 2'(skid_push) - 2'(skid_pop);
        end
    end
`else
    assign in_ready = ready[0] & ~flush;
    assign stage[0] = {in_valid, in_data};
    assign in_xfer  = in_valid & in_ready;
`endif

    assign out_valid = stage[DEPTH].valid;
    assign out_data  = stage[DEPTH].data;
    assign out_xfer  = out_valid & out_ready;
    assign occupancy = occ_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: queue-based model plus directed scenarios.
// Honours PIPE_STAGE_CHAIN_SKID_EN to select the expected latency and capacity.
module tb_pipe_stage_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int OCC_W = $clog2(DEPTH + 3);
`ifdef PIPE_STAGE_CHAIN_SKID_EN
    localparam bit SKID = 1'b1;
    localparam int LAT  = DEPTH + 1;
    localparam int CAP  = DEPTH + 2;
`else
    localparam bit SKID = 1'b0;
    localparam int LAT  = DEPTH;
    localparam int CAP  = DEPTH;
`endif

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    int total;
    int bad;
    int cyc;
    bit chk_en;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               age;
    } item_t;

    item_t            mq[$];
    logic [WIDTH-1:0] out_log[$];
    int               acc_cyc[256];
    int               vis_cyc[256];
    bit               m_xi;
    bit               m_xo;

    pipe_stage_chain #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .DATA_RST ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // The oldest item has nothing ahead of it, so it reaches the output LAT-1 edges after acceptance.
    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].age >= LAT - 1);
    endfunction

    function automatic bit m_in_ready();
        if (flush) return 1'b0;
        if (SKID) return mq.size() < CAP;
        return (mq.size() < CAP) || out_ready;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            cyc = 0;
        end else begin
            m_xi = in_valid && m_in_ready();
            m_xo = m_out_valid() && out_ready;
            cyc++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_xo) void'(mq.pop_front());
                foreach (mq[i]) mq[i].age++;
                if (m_xi) mq.push_back('{data: in_data, age: 0});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            checkOutput("out_valid", out_valid, m_out_valid());
            checkOutput("occupancy", occupancy, mq.size());
            checkOutput("in_ready", in_ready, m_in_ready());
            if (m_out_valid()) checkOutput("out_data", out_data, mq[0].data);
            if (in_valid && in_ready && acc_cyc[in_data] < 0) acc_cyc[in_data] = cyc;
            if (out_valid && vis_cyc[out_data] < 0) vis_cyc[out_data] = cyc;
            if (out_valid && out_ready) out_log.push_back(out_data);
        end
    end

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #2;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Offers one item and holds it until accepted or the cycle budget runs out.
    task automatic offerHold(input logic [WIDTH-1:0] d, input logic ordy, input int maxc, output bit got);
        got = 1'b0;
        applyStimulus(1'b1, d, ordy, 1'b0);
        for (int c = 0; c < maxc && !got; c++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        int base;
        int expect_out;

        clk = 1'b0; reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        chk_en = 1'b0; total = 0; bad = 0;
        foreach (acc_cyc[i]) acc_cyc[i] = -1;
        foreach (vis_cyc[i]) vis_cyc[i] = -1;

        #12;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_occupancy", occupancy, 0);
        @(posedge clk);
        #2;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1'b1);

        $display("[TB] streaming 0x01..0x05");
        for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 8'(k), 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (LAT + 3) @(negedge clk);
        checkOutput("stream_latency", vis_cyc[1] - acc_cyc[1], LAT);
        for (int k = 1; k < 5; k++) checkOutput("stream_gap", vis_cyc[k+1] - vis_cyc[k], 1);
        checkOutput("stream_count", out_log.size(), 5);
        for (int i = 0; i < 5; i++) if (i < out_log.size()) checkOutput("stream_order", out_log[i], i + 1);

        $display("[TB] back-pressure");
        base = out_log.size();
        for (int k = 0; k <= CAP; k++) begin
            offerHold(8'(8'h10 + k), 1'b0, 4, got);
            checkOutput("bp_accept", got, k < CAP);
        end
        checkOutput("bp_occupancy", occupancy, CAP);
        checkOutput("bp_in_ready", in_ready, 1'b0);
        offerHold(8'(8'h10 + CAP), 1'b1, 4, got);
        checkOutput("bp_release_accept", got, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (LAT + CAP + 2) @(negedge clk);
        for (int k = 0; k <= CAP; k++)
            if (base + k < out_log.size()) checkOutput("bp_order", out_log[base+k], 8'h10 + k);

        $display("[TB] single item under stall");
        offerHold(8'hAA, 1'b0, 4, got);
        checkOutput("single_accept", got, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("single_occupancy", occupancy, 1);
        checkOutput("single_in_ready", in_ready, 1'b1);
        checkOutput("single_out_valid", out_valid, 1'b1);
        checkOutput("single_out_data", out_data, 8'hAA);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] flush");
        for (int k = 0; k < 3; k++) begin
            offerHold(8'(8'h30 + k), 1'b0, 4, got);
            checkOutput("flush_fill_accept", got, 1'b1);
        end
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush_pre_occupancy", occupancy, 3);
        checkOutput("flush_in_ready", in_ready, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush_out_valid", out_valid, 1'b0);
        checkOutput("flush_occupancy", occupancy, 0);
        checkOutput("flush_not_accepted", acc_cyc[8'h33], -1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (LAT + 2) @(negedge clk);

        expect_out = 5 + (CAP + 1) + 1;
`ifdef PIPE_STAGE_CHAIN_SKID_EN
        $display("[TB] skid capacity and latency");
        base = out_log.size();
        for (int k = 0; k <= 5; k++) begin
            offerHold(8'(8'h20 + k), 1'b0, 6, got);
            checkOutput("skid_accept", got, k < 5);
        end
        checkOutput("skid_occupancy", occupancy, 5);
        checkOutput("skid_in_ready", in_ready, 1'b0);
        checkOutput("skid_latency", vis_cyc[8'h20] - acc_cyc[8'h20], 4);
        offerHold(8'h25, 1'b1, 6, got);
        checkOutput("skid_release_accept", got, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 6; k++)
            if (base + k < out_log.size()) checkOutput("skid_order", out_log[base+k], 8'h20 + k);
        expect_out = expect_out + 6;
`endif
        checkOutput("total_outputs", out_log.size(), expect_out);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
